// File: rtl/p_reduce_pkg.sv
// Shared encodings for the sequential bitwise reducer: operation codes,
// FSM states and the per-operation fold identity.
package p_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Every bit of the identity is the same, so callers replicate this to width.
  function automatic logic identity_bit(op_e op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/p_reduce_comb.sv
// One fold step: combines the accumulator with LANES buses under op.
// Disabled lanes contribute the identity so a partial last chunk is neutral.
module p_reduce_comb
  import p_reduce_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int LANES     = 1
) (
  input  op_e                             op,
  input  logic [BUS_WIDTH-1:0]            acc,
  input  logic [LANES-1:0][BUS_WIDTH-1:0] lanes,
  input  logic [LANES-1:0]                lane_en,
  output logic [BUS_WIDTH-1:0]            res
);

  logic [BUS_WIDTH-1:0] ident;
  assign ident = {BUS_WIDTH{identity_bit(op)}};

  always_comb begin
    res = acc;
    for (int l = 0; l < LANES; l++) begin
      case (op)
        OP_AND, OP_NAND: res = res & (lane_en[l] ? lanes[l] : ident);
        OP_OR:           res = res | (lane_en[l] ? lanes[l] : ident);
        default:         res = res ^ (lane_en[l] ? lanes[l] : ident);
      endcase
    end
  end

endmodule

// File: rtl/p_reduce_seq.sv
// Sequential multi-mode bitwise reducer: snapshots NB_INS buses, folds LANES
// per cycle, and returns the result through a valid/ready handshake.
module p_reduce_seq
  import p_reduce_pkg::*;
#(
  parameter int BUS_WIDTH = 4,
  parameter int NB_INS    = 3,
  parameter int LANES     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        op,
  input  logic [NB_INS-1:0][BUS_WIDTH-1:0]  in_buses,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BUS_WIDTH-1:0]              out_bus,
  output logic                              busy
);

  localparam int PTR_W = $clog2(NB_INS + LANES);

  state_e                              state_q, state_d;
  op_e                                 op_q, op_d;
  logic [NB_INS-1:0][BUS_WIDTH-1:0]    snap_q, snap_d;
  logic [BUS_WIDTH-1:0]                acc_q, acc_d;
  logic [PTR_W-1:0]                    ptr_q, ptr_d;
  logic [BUS_WIDTH-1:0]                out_bus_q, out_bus_d;
  logic                                out_valid_q, out_valid_d;

  logic [NB_INS+LANES-1:0][BUS_WIDTH-1:0] padded;
  logic [LANES-1:0][BUS_WIDTH-1:0]        lanes;
  logic [LANES-1:0]                       lane_en;
  logic [BUS_WIDTH-1:0]                   fold_res;
  logic                                   last_chunk;

  // Padding the snapshot lets ptr+l index past NB_INS without a range check.
  always_comb begin
    padded = '0;
    padded[NB_INS-1:0] = snap_q;
    lanes   = '0;
    lane_en = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [PTR_W-1:0] idx;
      idx        = ptr_q + PTR_W'(l);
      lanes[l]   = padded[idx];
      lane_en[l] = idx < PTR_W'(NB_INS);
    end
  end

  assign last_chunk = (int'(ptr_q) + LANES) >= NB_INS;

  p_reduce_comb #(
    .BUS_WIDTH (BUS_WIDTH),
    .LANES     (LANES)
  ) u_comb (
    .op      (op_q),
    .acc     (acc_q),
    .lanes   (lanes),
    .lane_en (lane_en),
    .res     (fold_res)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    snap_d      = snap_q;
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    out_bus_d   = out_bus_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          snap_d  = in_buses;
          op_d    = op_e'(op);
          acc_d   = {BUS_WIDTH{identity_bit(op_e'(op))}};
          ptr_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = fold_res;
        ptr_d = ptr_q + PTR_W'(LANES);
        if (last_chunk) begin
          out_bus_d   = (op_q == OP_NAND) ? ~fold_res : fold_res;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      snap_q      <= '0;
      acc_q       <= '0;
      ptr_q       <= '0;
      out_bus_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      out_bus_q   <= out_bus_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_bus   = out_bus_q;

endmodule

// File: tb/tb_p_reduce_seq.sv
// Bench for p_reduce_seq: LANES=1 and LANES=2 instances checked every cycle
// against a transaction-level model, plus hand-computed result literals.
module tb_p_reduce_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       op;
  logic [2:0][3:0]  buses;
  logic             iv_a, iv_b, ordy_a, ordy_b;
  logic             ir_a, ir_b, ov_a, ov_b, busy_a, busy_b;
  logic [3:0]       ob_a, ob_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  p_reduce_seq #(.BUS_WIDTH(4), .NB_INS(3), .LANES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .op(op),
    .in_buses(buses), .out_valid(ov_a), .out_ready(ordy_a), .out_bus(ob_a),
    .busy(busy_a)
  );

  p_reduce_seq #(.BUS_WIDTH(4), .NB_INS(3), .LANES(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .op(op),
    .in_buses(buses), .out_valid(ov_b), .out_ready(ordy_b), .out_bus(ob_b),
    .busy(busy_b)
  );

  // Transaction-level model: phase 0 idle, 1 folding (cnt cycles left), 2 done.
  typedef struct {
    int         phase;
    int         cnt;
    logic [3:0] res;
    logic [3:0] ob;
  } model_t;

  model_t ma = '{phase: 0, cnt: 0, res: 4'h0, ob: 4'h0};
  model_t mb = '{phase: 0, cnt: 0, res: 4'h0, ob: 4'h0};

  function automatic logic [3:0] reduce(input logic [1:0] o, input logic [2:0][3:0] b);
    logic [3:0] r;
    r = (o == 2'b00 || o == 2'b11) ? 4'hf : 4'h0;
    for (int i = 0; i < 3; i++) begin
      case (o)
        2'b00, 2'b11: r = r & b[i];
        2'b01:        r = r | b[i];
        default:      r = r ^ b[i];
      endcase
    end
    if (o == 2'b11) r = ~r;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input logic r, input logic iv,
                                  input logic [1:0] o, input logic [2:0][3:0] b,
                                  input logic ordy, input int c);
    model_t n;
    n = m;
    if (r) begin
      n.phase = 0;
      n.cnt   = 0;
      n.ob    = 4'h0;
    end else begin
      case (m.phase)
        0: if (iv) begin
          n.res   = reduce(o, b);
          n.cnt   = c;
          n.phase = 1;
        end
        1: begin
          n.cnt = m.cnt - 1;
          if (n.cnt == 0) begin
            n.phase = 2;
            n.ob    = m.res;
          end
        end
        default: if (ordy) n.phase = 0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, rst, iv_a, op, buses, ordy_a, (3 + 1 - 1) / 1);
    mb = step(mb, rst, iv_b, op, buses, ordy_b, (3 + 2 - 1) / 2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_in_ready",  32'(ir_a),   32'(ma.phase == 0));
      chk("a_busy",      32'(busy_a), 32'(ma.phase == 1));
      chk("a_out_valid", 32'(ov_a),   32'(ma.phase == 2));
      chk("a_out_bus",   32'(ob_a),   32'(ma.ob));
      chk("b_in_ready",  32'(ir_b),   32'(mb.phase == 0));
      chk("b_busy",      32'(busy_b), 32'(mb.phase == 1));
      chk("b_out_valid", 32'(ov_b),   32'(mb.phase == 2));
      chk("b_out_bus",   32'(ob_b),   32'(mb.ob));
    end
  end

  function automatic logic cur_ir(input bit s);   return s ? ir_b   : ir_a;   endfunction
  function automatic logic cur_ov(input bit s);   return s ? ov_b   : ov_a;   endfunction
  function automatic logic cur_busy(input bit s); return s ? busy_b : busy_a; endfunction
  function automatic logic [3:0] cur_ob(input bit s); return s ? ob_b : ob_a; endfunction

  task automatic set_iv(input bit s, input logic v);
    if (s) iv_b = v; else iv_a = v;
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) ordy_b = v; else ordy_a = v;
  endtask

  task automatic txn(input bit sel, input logic [1:0] o, input logic [2:0][3:0] b,
                     input logic [3:0] exp, input int exp_lat, input int stall,
                     input bit iso, input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    op    = o;
    buses = b;
    set_iv(sel, 1'b1);
    set_ordy(sel, stall == 0);
    @(negedge clk);
    set_iv(sel, 1'b0);
    chk({tag, "_in_ready_drop"}, 32'(cur_ir(sel)), 32'(0));
    if (iso) begin
      buses = '0;
      op    = 2'b01;
    end
    lat  = 0;
    bcnt = 0;
    while (!cur_ov(sel) && lat < 20) begin
      bcnt += int'(cur_busy(sel));
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"},    32'(lat),         32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt),       32'(exp_lat));
    chk({tag, "_result"},     32'(cur_ob(sel)), 32'(exp));
    for (int k = 0; k < stall; k++) begin
      set_iv(sel, 1'b1);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(cur_ov(sel)), 32'(1));
      chk({tag, "_hold_bus"},   32'(cur_ob(sel)), 32'(exp));
      chk({tag, "_hold_ready"}, 32'(cur_ir(sel)), 32'(0));
    end
    set_iv(sel, 1'b0);
    set_ordy(sel, 1'b1);
    @(negedge clk);
    chk({tag, "_release_valid"}, 32'(cur_ov(sel)), 32'(0));
    chk({tag, "_release_ready"}, 32'(cur_ir(sel)), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    op     = 2'b00;
    buses  = '0;
    iv_a   = 1'b0;
    iv_b   = 1'b0;
    ordy_a = 1'b1;
    ordy_b = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_in_ready",  32'(ir_a),   32'(1));
    chk("reset_out_valid", 32'(ov_a),   32'(0));
    chk("reset_out_bus",   32'(ob_a),   32'(0));
    chk("reset_busy",      32'(busy_a), 32'(0));

    txn(1'b0, 2'b00, {4'b1111, 4'b1011, 4'b1101}, 4'b1001, 3, 0, 1'b0, "and");
    txn(1'b0, 2'b10, {4'b1111, 4'b1011, 4'b1101}, 4'b1001, 3, 0, 1'b0, "xor");
    txn(1'b0, 2'b11, {4'b1111, 4'b1011, 4'b1101}, 4'b0110, 3, 0, 1'b0, "nand");
    txn(1'b0, 2'b01, {4'b0100, 4'b0010, 4'b0001}, 4'b0111, 3, 0, 1'b0, "or");
    txn(1'b0, 2'b00, {4'b1111, 4'b1011, 4'b1101}, 4'b1001, 3, 5, 1'b0, "stall");
    txn(1'b0, 2'b00, {4'b1111, 4'b1011, 4'b1101}, 4'b1001, 3, 0, 1'b1, "iso");
    txn(1'b1, 2'b00, {4'b0111, 4'b1011, 4'b1101}, 4'b0001, 2, 0, 1'b0, "lanes2_and");
    txn(1'b1, 2'b11, {4'b0111, 4'b1011, 4'b1101}, 4'b1110, 2, 0, 1'b0, "lanes2_nand");

    // Reset one edge after the first fold.
    @(negedge clk);
    op    = 2'b00;
    buses = {4'b1111, 4'b1011, 4'b1101};
    iv_a  = 1'b1;
    @(negedge clk);
    iv_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  32'(ir_a),   32'(1));
    chk("midrst_out_valid", 32'(ov_a),   32'(0));
    chk("midrst_out_bus",   32'(ob_a),   32'(0));
    chk("midrst_busy",      32'(busy_a), 32'(0));

    txn(1'b0, 2'b10, {4'b0011, 4'b0101, 4'b1000}, 4'b1110, 3, 0, 1'b0, "post_reset_xor");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
